// File: rtl/rtc_pkg.sv
// Shared constants for the PCF8563 snapshot to FAT timestamp path:
// field layout inside the 56-bit snapshot, masks, epoch offsets and FSM states.
package rtc_pkg;

  localparam int SEC_LSB  = 48;
  localparam int MIN_LSB  = 40;
  localparam int HOUR_LSB = 32;
  localparam int DAY_LSB  = 24;
  localparam int WDAY_LSB = 16;
  localparam int CM_LSB   = 8;
  localparam int YEAR_LSB = 0;

  localparam int VL_BIT   = 55;
  localparam int CENT_BIT = 15;

  localparam logic [7:0] SEC_MASK   = 8'h7F;
  localparam logic [7:0] MIN_MASK   = 8'h7F;
  localparam logic [7:0] HOUR_MASK  = 8'h3F;
  localparam logic [7:0] DAY_MASK   = 8'h3F;
  localparam logic [7:0] MONTH_MASK = 8'h1F;
  localparam logic [7:0] YEAR_MASK  = 8'hFF;

  localparam logic [7:0] FAT_EPOCH_OFS_C0 = 8'd20;
  localparam logic [7:0] FAT_EPOCH_OFS_C1 = 8'd120;

  localparam int FAT_YEAR_W = 7;
  localparam int FAT_MON_W  = 4;
  localparam int FAT_DAY_W  = 5;
  localparam int FAT_HOUR_W = 5;
  localparam int FAT_MIN_W  = 6;
  localparam int FAT_SEC_W  = 5;

  // Conversion order through the shared BCD converter
  localparam logic [2:0] FLD_SEC   = 3'd0;
  localparam logic [2:0] FLD_MIN   = 3'd1;
  localparam logic [2:0] FLD_HOUR  = 3'd2;
  localparam logic [2:0] FLD_DAY   = 3'd3;
  localparam logic [2:0] FLD_MONTH = 3'd4;
  localparam logic [2:0] FLD_YEAR  = 3'd5;

  typedef enum logic [2:0] {
    IDLE,
    SAMPLE,
    CONVERT,
    CHECK,
    PUBLISH
  } state_t;

  function automatic logic [7:0] get_field(input logic [55:0] raw, input int lsb,
                                           input logic [7:0] mask);
    return raw[lsb +: 8] & mask;
  endfunction

endpackage

// File: rtl/rtc_fat_timestamp_bcd_to_bin.sv
// Combinational two-digit BCD to binary converter; flags any nibble above 9.
module bcd_to_bin (
  input  logic [7:0] bcd,
  output logic [6:0] bin,
  output logic       nibble_err
);

  logic [3:0] tens;
  logic [3:0] units;

  assign tens       = bcd[7:4];
  assign units      = bcd[3:0];
  // tens*10 as shift-add, kept in 7 bits
  assign bin        = {tens, 3'b000} + {2'b00, tens, 1'b0} + {3'b000, units};
  assign nibble_err = (tens > 4'd9) | (units > 4'd9);

endmodule

// File: rtl/rtc_fat_timestamp.sv
// Samples the PCF8563 BCD snapshot, rejects torn/invalid reads and publishes a
// packed FAT timestamp with valid/strobe handshake.
//
//   state   | meaning
//   IDLE    | waiting for the divider tick
//   SAMPLE  | capture rtc, update stability count, decide whether to convert
//   CONVERT | six cycles, one BCD field per cycle through bcd_to_bin
//   CHECK   | accept or reject the converted sample
//   PUBLISH | outputs carry the new value, ts_strobe high
module rtc_fat_timestamp
  import rtc_pkg::*;
#(
  parameter int SAMPLE_DIV   = 1024,
  parameter int STABLE_COUNT = 2
) (
  input  logic        mclk,
  input  logic        reset,
  input  logic [55:0] rtc,
  output logic [31:0] fat_ts,
  output logic [2:0]  weekday,
  output logic        vl,
  output logic        ts_valid,
  output logic        ts_strobe,
  output logic        bcd_err
);

  localparam int         DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [2:0] STABLE_TGT = 3'(STABLE_COUNT);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;

  state_t      state;
  state_t      state_next;
  logic [55:0] sample_q;
  logic [55:0] last_raw;
  logic [2:0]  stable_cnt;
  logic [2:0]  stable_next;
  logic        start_conv;
  logic [2:0]  conv_idx;
  logic        err_acc;

  logic [FAT_SEC_W-1:0]  sec_half;
  logic [FAT_MIN_W-1:0]  min_fat;
  logic [FAT_HOUR_W-1:0] hour_fat;
  logic [FAT_DAY_W-1:0]  day_fat;
  logic [FAT_MON_W-1:0]  mon_fat;
  logic [FAT_YEAR_W-1:0] year_fat;

  logic [7:0] bcd_in;
  logic [6:0] bin;
  logic       nibble_err;
  logic [7:0] year_sum;
  logic       range_bad;

  assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
    end else if (tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_comb begin
    stable_next = 3'd1;
    if (rtc == sample_q) begin
      stable_next = (stable_cnt == 3'd7) ? 3'd7 : stable_cnt + 3'd1;
    end
    // all-zero snapshot means the poller has nothing yet
    start_conv = (stable_next >= STABLE_TGT) && (rtc != last_raw) && (rtc != '0);
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (tick) state_next = SAMPLE;
      SAMPLE:  state_next = start_conv ? CONVERT : IDLE;
      CONVERT: if (conv_idx == FLD_YEAR) state_next = CHECK;
      CHECK:   state_next = err_acc ? IDLE : PUBLISH;
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    bcd_in = 8'h00;
    case (conv_idx)
      FLD_SEC:   bcd_in = get_field(sample_q, SEC_LSB,  SEC_MASK);
      FLD_MIN:   bcd_in = get_field(sample_q, MIN_LSB,  MIN_MASK);
      FLD_HOUR:  bcd_in = get_field(sample_q, HOUR_LSB, HOUR_MASK);
      FLD_DAY:   bcd_in = get_field(sample_q, DAY_LSB,  DAY_MASK);
      FLD_MONTH: bcd_in = get_field(sample_q, CM_LSB,   MONTH_MASK);
      FLD_YEAR:  bcd_in = get_field(sample_q, YEAR_LSB, YEAR_MASK);
      default:   bcd_in = 8'h00;
    endcase
  end

  bcd_to_bin u_bcd_to_bin (
    .bcd        (bcd_in),
    .bin        (bin),
    .nibble_err (nibble_err)
  );

  assign year_sum = {1'b0, bin} + (sample_q[CENT_BIT] ? FAT_EPOCH_OFS_C1 : FAT_EPOCH_OFS_C0);

  always_comb begin
    range_bad = 1'b0;
    case (conv_idx)
      FLD_SEC:   range_bad = (bin > 7'd59);
      FLD_MIN:   range_bad = (bin > 7'd59);
      FLD_HOUR:  range_bad = (bin > 7'd23);
      FLD_DAY:   range_bad = (bin == 7'd0) || (bin > 7'd31);
      FLD_MONTH: range_bad = (bin == 7'd0) || (bin > 7'd12);
      FLD_YEAR:  range_bad = (year_sum > 8'd127);
      default:   range_bad = 1'b0;
    endcase
  end

  always_ff @(posedge mclk or negedge reset) begin
    if (!reset) begin
      sample_q   <= '0;
      last_raw   <= '0;
      stable_cnt <= '0;
      conv_idx   <= '0;
      err_acc    <= 1'b0;
      sec_half   <= '0;
      min_fat    <= '0;
      hour_fat   <= '0;
      day_fat    <= '0;
      mon_fat    <= '0;
      year_fat   <= '0;
      fat_ts     <= '0;
      weekday    <= '0;
      vl         <= 1'b0;
      ts_valid   <= 1'b0;
      ts_strobe  <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      ts_strobe <= 1'b0;
      case (state)
        SAMPLE: begin
          sample_q   <= rtc;
          stable_cnt <= stable_next;
          conv_idx   <= FLD_SEC;
          err_acc    <= 1'b0;
        end
        CONVERT: begin
          err_acc  <= err_acc | nibble_err | range_bad;
          conv_idx <= conv_idx + 3'd1;
          case (conv_idx)
            FLD_SEC:   sec_half <= bin[5:1];
            FLD_MIN:   min_fat  <= bin[5:0];
            FLD_HOUR:  hour_fat <= bin[4:0];
            FLD_DAY:   day_fat  <= bin[4:0];
            FLD_MONTH: mon_fat  <= bin[3:0];
            FLD_YEAR:  year_fat <= year_sum[6:0];
            default:   ;
          endcase
        end
        CHECK: begin
          if (err_acc) begin
            bcd_err <= 1'b1;
          end else begin
            // registered here so the new value and the strobe appear in PUBLISH
            fat_ts    <= {year_fat, mon_fat, day_fat, hour_fat, min_fat, sec_half};
            weekday   <= sample_q[WDAY_LSB +: 3];
            vl        <= sample_q[VL_BIT];
            ts_valid  <= 1'b1;
            bcd_err   <= 1'b0;
            ts_strobe <= 1'b1;
            last_raw  <= sample_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_fat_timestamp.sv
// Scoreboard bench for rtc_fat_timestamp: stimulus queues expected publishes,
// a strobe monitor pops and compares value and arrival cycle.
module tb_rtc_fat_timestamp;

  localparam int DIV = 32;

  logic        mclk = 1'b0;
  logic        reset = 1'b0;
  logic [55:0] rtc = '0;
  logic [31:0] fat_ts;
  logic [2:0]  weekday;
  logic        vl;
  logic        ts_valid;
  logic        ts_strobe;
  logic        bcd_err;

  rtc_fat_timestamp #(.SAMPLE_DIV(DIV), .STABLE_COUNT(2)) dut (
    .mclk      (mclk),
    .reset     (reset),
    .rtc       (rtc),
    .fat_ts    (fat_ts),
    .weekday   (weekday),
    .vl        (vl),
    .ts_valid  (ts_valid),
    .ts_strobe (ts_strobe),
    .bcd_err   (bcd_err)
  );

  always #5 mclk = ~mclk;

  // cycles since reset release; equals the DUT divider phase
  int cyc;
  always @(posedge mclk or negedge reset) begin
    if (!reset) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [31:0] fat;
    logic [2:0]  wd;
    logic        v;
    int          at;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  logic prev_strobe = 1'b0;

  localparam logic [55:0] NOM   = 56'h45_30_12_15_03_06_24;
  localparam logic [55:0] TORN  = 56'h45_31_13_15_03_06_24;
  localparam logic [55:0] MIN31 = 56'h45_31_12_15_03_06_24;
  localparam logic [55:0] FLG1  = 56'hC5_30_12_15_03_86_05;
  localparam logic [55:0] FLG2  = 56'hC5_30_12_15_03_86_24;
  localparam logic [55:0] BADM  = 56'h45_5A_12_15_03_06_24;
  localparam logic [55:0] BADMO = 56'h45_30_12_15_03_13_24;
  localparam logic [55:0] MAXV  = 56'h59_59_23_31_06_12_99;
  localparam logic [55:0] Y127  = 56'h01_00_00_01_00_81_07;
  localparam logic [55:0] Y128  = 56'h01_00_00_01_00_81_08;
  localparam logic [55:0] DAY0  = 56'h01_00_00_00_00_01_07;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge mclk) begin
    if (!reset) begin
      prev_strobe = 1'b0;
    end else begin
      if (ts_strobe) begin
        check("strobe_back_to_back", 32'(prev_strobe), 32'd0);
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_strobe: got fat_ts=%h at cycle %0d, expected none", fat_ts, cyc);
        end else begin
          mon_e = sb.pop_front();
          check("fat_ts",       fat_ts,           mon_e.fat);
          check("weekday",      32'(weekday),     32'(mon_e.wd));
          check("vl",           32'(vl),          32'(mon_e.v));
          check("ts_valid_pub", 32'(ts_valid),    32'd1);
          check("bcd_err_pub",  32'(bcd_err),     32'd0);
          check("strobe_cycle", 32'(cyc),         32'(mon_e.at));
        end
      end
      prev_strobe = ts_strobe;
    end
  end

  task automatic wait_phase(input int ph);
    do @(negedge mclk); while ((cyc % DIV) != ph);
  endtask

  // Drive a new snapshot mid-period, queue the expected publish if any, then
  // wait three sample periods so the publish (or its absence) has played out.
  task automatic apply(input logic [55:0] val, input logic pub, input logic [31:0] fat,
                       input logic [2:0] wd, input logic v);
    int m;
    wait_phase(16);
    rtc = val;
    m = cyc / DIV;
    if (pub) sb.push_back('{fat, wd, v, DIV * (m + 2) + 8});
    while (cyc < DIV * (m + 3) + 16) @(negedge mclk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL missed_strobe: got none by cycle %0d, expected fat_ts=%h", cyc, sb[0].fat);
      sb.delete();
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_fat_ts"},    fat_ts,           32'd0);
    check({tag, "_weekday"},   32'(weekday),     32'd0);
    check({tag, "_vl"},        32'(vl),          32'd0);
    check({tag, "_ts_valid"},  32'(ts_valid),    32'd0);
    check({tag, "_ts_strobe"}, 32'(ts_strobe),   32'd0);
    check({tag, "_bcd_err"},   32'(bcd_err),     32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] r;
    int m;

    reset = 1'b0;
    r = {$urandom(), $urandom()};
    rtc = r[55:0];
    repeat (5) @(negedge mclk);
    check_zero_outputs("reset");

    rtc = '0;
    reset = 1'b1;
    repeat (4 * DIV) @(negedge mclk);
    check("zero_snap_ts_valid", 32'(ts_valid), 32'd0);
    check("zero_snap_bcd_err",  32'(bcd_err),  32'd0);

    apply(NOM, 1'b1, 32'h58CF63D6, 3'd3, 1'b0);
    apply(NOM, 1'b0, 32'h0, 3'd0, 1'b0);
    check("nominal_hold_fat", fat_ts, 32'h58CF63D6);

    // torn read one cycle before capture, then settles on min=31
    wait_phase(0);
    rtc = TORN;
    apply(MIN31, 1'b1, 32'h58CF63F6, 3'd3, 1'b0);

    apply(FLG1, 1'b1, 32'hFACF63D6, 3'd3, 1'b1);
    check("flags_year_field", 32'(fat_ts[31:25]), 32'd125);
    check("flags_sec_field",  32'(fat_ts[4:0]),   32'd22);
    apply(FLG2, 1'b0, 32'h0, 3'd0, 1'b0);
    check("yr144_bcd_err",  32'(bcd_err), 32'd1);
    check("yr144_fat_hold", fat_ts,       32'hFACF63D6);
    check("yr144_vl_hold",  32'(vl),      32'd1);

    apply(NOM, 1'b1, 32'h58CF63D6, 3'd3, 1'b0);
    check("recover_bcd_err", 32'(bcd_err), 32'd0);

    apply(BADM, 1'b0, 32'h0, 3'd0, 1'b0);
    check("min5a_bcd_err",  32'(bcd_err),  32'd1);
    check("min5a_ts_valid", 32'(ts_valid), 32'd1);
    apply(BADMO, 1'b0, 32'h0, 3'd0, 1'b0);
    check("mon13_bcd_err",  32'(bcd_err),  32'd1);
    check("mon13_fat_hold", fat_ts,        32'h58CF63D6);

    apply(MAXV, 1'b1, 32'hEF9FBF7D, 3'd6, 1'b0);
    check("maxv_bcd_err", 32'(bcd_err), 32'd0);
    apply(Y127, 1'b1, 32'hFE210000, 3'd0, 1'b0);
    apply(Y128, 1'b0, 32'h0, 3'd0, 1'b0);
    check("yr128_bcd_err", 32'(bcd_err), 32'd1);
    apply(DAY0, 1'b0, 32'h0, 3'd0, 1'b0);
    check("day0_bcd_err",  32'(bcd_err), 32'd1);
    check("day0_fat_hold", fat_ts,       32'hFE210000);

    // reset lands in the third CONVERT cycle of a qualifying sample
    wait_phase(16);
    rtc = NOM;
    m = cyc / DIV;
    while (cyc != DIV * (m + 2) + 3) @(negedge mclk);
    reset = 1'b0;
    #1;
    check_zero_outputs("midconv");
    repeat (3) @(negedge mclk);
    reset = 1'b1;
    apply(NOM, 1'b1, 32'h58CF63D6, 3'd3, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
